// File: rtl/huff_pair_engine_if.sv
// Stream and table-lookup bundle for huff_pair_engine: bit input, codeword lookup, pair output.
// slave is the engine side; master is the reservoir/table/requantiser side.
interface huff_pair_engine_if #(
   parameter int MAX_BITS = 19,
   parameter int LEN_W    = 5,
   parameter int OUT_W    = 16
);
   logic                       axiiv;
   logic                       axiid;
   logic                       axiir;
   logic [MAX_BITS-1:0]        lk_code;
   logic [LEN_W-1:0]           lk_len;
   logic                       lk_found;
   logic [3:0]                 lk_x;
   logic [3:0]                 lk_y;
   logic                       axiov;
   logic                       axior;
   logic signed [OUT_W-1:0]    x_val;
   logic signed [OUT_W-1:0]    y_val;

   modport slave (
      input  axiiv, axiid, lk_found, lk_x, lk_y, axior,
      output axiir, lk_code, lk_len, axiov, x_val, y_val
   );

   modport master (
      output axiiv, axiid, lk_found, lk_x, lk_y, axior,
      input  axiir, lk_code, lk_len, axiov, x_val, y_val
   );
endinterface

// File: rtl/huff_pair_engine.sv
// Bit-serial MP3 big_values Huffman pair decoder: codeword match, linbits escape, signs.
// Optional macro HUFF_ERR_EN adds err/err_flag and aborts a run on codeword overflow.
module huff_pair_engine #(
   parameter int MAX_BITS = 19,
   parameter int LEN_W    = 5,
   parameter int LIN_MAX  = 13,
   parameter int CNT_W    = 9,
   parameter int OUT_W    = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [3:0]         linbits,
   input  logic [CNT_W-1:0]   pair_count,
   output logic               done,
   huff_pair_engine_if.slave  bus
`ifdef HUFF_ERR_EN
   ,
   output logic               err,
   output logic               err_flag
`endif
);

   typedef enum logic [2:0] {IDLE, CODE, LINX, SGNX, LINY, SGNY, OUT} state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [3:0]              lin_bits_q;
   logic [CNT_W-1:0]        remaining;
   logic [3:0]              abs_x;
   logic [3:0]              abs_y;
   logic [LIN_MAX-1:0]      lin_x;
   logic [LIN_MAX-1:0]      lin_y;
   logic                    sgn_x;
   logic                    sgn_y;
   logic [3:0]              lin_cnt;
   logic [MAX_BITS-1:0]     lk_code_q;
   logic [LEN_W-1:0]        lk_len_q;
   logic signed [OUT_W-1:0] x_q;
   logic signed [OUT_W-1:0] y_q;
   logic                    done_q;

   logic                    accept;
   logic                    hit;
   logic                    full;
   logic                    lin_last;
   logic                    sgn_x_n;
   logic                    sgn_y_n;
   logic [MAX_BITS-1:0]     code_ins;

   // After the y magnitude is known, pick the first y state that still needs bits.
   function automatic state_t y_chain(input logic [3:0] ay, input logic [3:0] lb);
      if (ay == 4'd15 && lb != 4'd0)
         return LINY;
      else if (ay != 4'd0)
         return SGNY;
      else
         return OUT;
   endfunction

   function automatic state_t x_chain(input logic [3:0] ax, input logic [3:0] ay,
                                      input logic [3:0] lb);
      if (ax == 4'd15 && lb != 4'd0)
         return LINX;
      else if (ax != 4'd0)
         return SGNX;
      else
         return y_chain(ay, lb);
   endfunction

   function automatic logic signed [OUT_W-1:0] make_val(input logic [3:0] a,
                                                        input logic [LIN_MAX-1:0] l,
                                                        input logic s);
      logic [OUT_W-1:0] mag;
      mag = OUT_W'(a) + OUT_W'(l);
      return s ? $signed(-mag) : $signed(mag);
   endfunction

   assign accept   = bus.axiiv && bus.axiir;
   assign hit      = (state == CODE) && bus.lk_found && (lk_len_q != '0);
   assign full     = (lk_len_q == LEN_W'(MAX_BITS));
   assign lin_last = (lin_cnt == lin_bits_q - 4'd1);
   assign sgn_x_n  = (state == SGNX) ? bus.axiid : sgn_x;
   assign sgn_y_n  = (state == SGNY) ? bus.axiid : sgn_y;

   // Incoming codeword bit lands just below the bits already collected.
   always_comb begin
      code_ins = lk_code_q;
      for (int i = 0; i < MAX_BITS; i++) begin
         if (i == MAX_BITS - 1 - int'(lk_len_q))
            code_ins[i] = bus.axiid;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic: every bit-consuming state moves only on an accepted bit.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = (pair_count == '0) ? IDLE : CODE;
         CODE: begin
            if (hit)
               state_nxt = x_chain(bus.lk_x, bus.lk_y, lin_bits_q);
`ifdef HUFF_ERR_EN
            else if (full)
               state_nxt = IDLE;
`endif
         end
         LINX: if (accept && lin_last) state_nxt = SGNX;
         SGNX: if (accept) state_nxt = y_chain(abs_y, lin_bits_q);
         LINY: if (accept && lin_last) state_nxt = SGNY;
         SGNY: if (accept) state_nxt = OUT;
         OUT:  if (bus.axior) state_nxt = (remaining == CNT_W'(1)) ? IDLE : CODE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode: a lookup-hit cycle holds off the source so no bit is lost.
   always_comb begin
      bus.axiir = 1'b0;
      bus.axiov = 1'b0;
      case (state)
`ifdef HUFF_ERR_EN
         CODE: bus.axiir = !hit && !full;
`else
         CODE: bus.axiir = !hit;
`endif
         LINX, SGNX, LINY, SGNY: bus.axiir = 1'b1;
         OUT:  bus.axiov = 1'b1;
         default: ;
      endcase
   end

   assign bus.lk_code = lk_code_q;
   assign bus.lk_len  = lk_len_q;
   assign bus.x_val   = x_q;
   assign bus.y_val   = y_q;
   assign done        = done_q;

   // Datapath: codeword collection, linbits shifting, signs, pair assembly and counting.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lin_bits_q <= '0;
         remaining  <= '0;
         abs_x      <= '0;
         abs_y      <= '0;
         lin_x      <= '0;
         lin_y      <= '0;
         sgn_x      <= 1'b0;
         sgn_y      <= 1'b0;
         lin_cnt    <= '0;
         lk_code_q  <= '0;
         lk_len_q   <= '0;
         x_q        <= '0;
         y_q        <= '0;
         done_q     <= 1'b0;
`ifdef HUFF_ERR_EN
         err        <= 1'b0;
         err_flag   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
`ifdef HUFF_ERR_EN
         err    <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (start) begin
                  lin_bits_q <= linbits;
                  remaining  <= pair_count;
                  if (pair_count == '0)
                     done_q <= 1'b1;
`ifdef HUFF_ERR_EN
                  err_flag <= 1'b0;
`endif
               end
            end
            CODE: begin
               if (hit) begin
                  abs_x     <= bus.lk_x;
                  abs_y     <= bus.lk_y;
                  lk_code_q <= '0;
                  lk_len_q  <= '0;
                  lin_x     <= '0;
                  lin_y     <= '0;
                  sgn_x     <= 1'b0;
                  sgn_y     <= 1'b0;
                  lin_cnt   <= '0;
               end else if (accept && !full) begin
                  lk_code_q <= code_ins;
                  lk_len_q  <= lk_len_q + LEN_W'(1);
               end
`ifdef HUFF_ERR_EN
               else if (full) begin
                  err       <= 1'b1;
                  err_flag  <= 1'b1;
                  lk_code_q <= '0;
                  lk_len_q  <= '0;
               end
`endif
            end
            LINX: begin
               if (accept) begin
                  lin_x   <= {lin_x[LIN_MAX-2:0], bus.axiid};
                  lin_cnt <= lin_last ? 4'd0 : lin_cnt + 4'd1;
               end
            end
            SGNX: if (accept) sgn_x <= bus.axiid;
            LINY: begin
               if (accept) begin
                  lin_y   <= {lin_y[LIN_MAX-2:0], bus.axiid};
                  lin_cnt <= lin_last ? 4'd0 : lin_cnt + 4'd1;
               end
            end
            SGNY: if (accept) sgn_y <= bus.axiid;
            OUT: begin
               if (bus.axior) begin
                  remaining <= remaining - CNT_W'(1);
                  if (remaining == CNT_W'(1))
                     done_q <= 1'b1;
               end
            end
            default: ;
         endcase

         // Pair values are built on the way into OUT so the last sign bit is used directly.
         if (state_nxt == OUT && state != OUT) begin
            if (state == CODE) begin
               x_q <= '0;
               y_q <= '0;
            end else begin
               x_q <= make_val(abs_x, lin_x, sgn_x_n);
               y_q <= make_val(abs_y, lin_y, sgn_y_n);
            end
         end
      end
   end

endmodule

// File: tb/tb_huff_pair_engine.sv
// Directed bench for huff_pair_engine with a small prefix-free stub table.
// Build with HUFF_ERR_EN defined to exercise the overflow error path at MAX_BITS=4.
module tb_huff_pair_engine;

`ifdef HUFF_ERR_EN
   localparam int MB = 4;
`else
   localparam int MB = 19;
`endif

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] linbits;
   logic [8:0] pair_count;
   logic       done;
`ifdef HUFF_ERR_EN
   logic       err;
   logic       err_flag;
`endif

   int passed;
   int total;
   int consumed;
   logic pending;

   huff_pair_engine_if #(.MAX_BITS(MB), .LEN_W(5), .OUT_W(16)) bus ();

   huff_pair_engine #(.MAX_BITS(MB), .LEN_W(5), .LIN_MAX(13), .CNT_W(9), .OUT_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .linbits    (linbits),
      .pair_count (pair_count),
      .done       (done),
      .bus        (bus)
`ifdef HUFF_ERR_EN
      ,
      .err        (err),
      .err_flag   (err_flag)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stub table: 1->(0,0) 010->(1,0) 011->(0,1) 0011->(15,15) 0010->(1,1) 0001->(15,1).
   logic [3:0] top4;
   assign top4 = bus.lk_code[MB-1 -: 4];
   always_comb begin
      bus.lk_found = 1'b0;
      bus.lk_x     = 4'd0;
      bus.lk_y     = 4'd0;
      case (bus.lk_len)
         5'd1: if (top4[3]) bus.lk_found = 1'b1;
         5'd3: begin
            if (top4[3:1] == 3'b010) begin bus.lk_found = 1'b1; bus.lk_x = 4'd1; end
            if (top4[3:1] == 3'b011) begin bus.lk_found = 1'b1; bus.lk_y = 4'd1; end
         end
         5'd4: begin
            if (top4 == 4'b0011) begin bus.lk_found = 1'b1; bus.lk_x = 4'd15; bus.lk_y = 4'd15; end
            if (top4 == 4'b0010) begin bus.lk_found = 1'b1; bus.lk_x = 4'd1;  bus.lk_y = 4'd1;  end
            if (top4 == 4'b0001) begin bus.lk_found = 1'b1; bus.lk_x = 4'd15; bus.lk_y = 4'd1;  end
         end
         default: ;
      endcase
   end

   // Bit-consumption monitor, sampled mid-cycle and counted on the edge.
   initial consumed = 0;
   always @(negedge clk) begin
      #1 pending = bus.axiiv && bus.axiir;
   end
   always @(posedge clk) begin
      if (rst && pending) consumed = consumed + 1;
   end

   typedef struct {
      logic [3:0]  lb;
      logic [31:0] bits;
      int          nbits;
      int          exp_x;
      int          exp_y;
      int          exp_lat;
   } vec_t;

   vec_t vecs[9];

   task automatic check_output(input string name, input int actual, input int expected);
      total = total + 1;
      if (actual == expected)
         passed = passed + 1;
      else
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   task automatic start_run(input logic [3:0] lb, input logic [8:0] pc);
      start      = 1'b1;
      linbits    = lb;
      pair_count = pc;
      @(negedge clk);
      start      = 1'b0;
   endtask

   task automatic put_bit(input logic b);
      bit ok;
      int guard;
      ok = 0;
      guard = 0;
      bus.axiiv = 1'b1;
      bus.axiid = b;
      while (!ok && guard < 20) begin
         if (bus.axiir) ok = 1;
         @(negedge clk);
         guard++;
      end
      bus.axiiv = 1'b0;
      if (!ok) check_output("bit_accept_timeout", 0, 1);
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!bus.axiov && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      if (!bus.axiov) check_output("out_timeout", 0, 1);
   endtask

   task automatic accept_pair();
      bus.axior = 1'b1;
      @(negedge clk);
      bus.axior = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   // One single-pair run from the vector table.
   task automatic apply_stimulus(input vec_t v, input int idx);
      int c0;
      int lat;
      string tag;
      tag = $sformatf("vec%0d", idx);
      start_run(v.lb, 9'd1);
      c0 = consumed;
      for (int i = v.nbits - 1; i >= 0; i--) put_bit(v.bits[i]);
      wait_out(lat);
      check_output({tag, "_latency"}, lat, v.exp_lat);
      check_output({tag, "_x"}, bus.x_val, v.exp_x);
      check_output({tag, "_y"}, bus.y_val, v.exp_y);
      check_output({tag, "_bits"}, consumed - c0, v.nbits);
      accept_pair();
      check_output({tag, "_done"}, done, 1);
      @(negedge clk);
      check_output({tag, "_done_low"}, done, 0);
   endtask

   initial begin
      int lat;
      int c0;
      int sx;
      int sy;
      passed = 0;
      total  = 0;
      rst = 1'b0;
      start = 1'b0;
      linbits = 4'd0;
      pair_count = '0;
      bus.axiiv = 1'b0;
      bus.axiid = 1'b0;
      bus.axior = 1'b0;

      vecs[0] = '{4'd0,  32'b1,                 1,  0,     0,   1};
      vecs[1] = '{4'd0,  32'b0101,              4, -1,     0,   0};
      vecs[2] = '{4'd0,  32'b0110,              4,  0,     1,   0};
      vecs[3] = '{4'd4,  32'b0011_0101_0_0010_1, 14, 20,  -17,   0};
      vecs[4] = '{4'd0,  32'b0011_1_0,          6, -15,   15,   0};
      vecs[5] = '{4'd0,  32'b0010_0_1,          6,  1,    -1,   0};
      vecs[6] = '{4'd13, 32'({4'b0001, 13'h1FFF, 1'b1, 1'b0}), 19, -8206, 1, 0};
      vecs[7] = '{4'd1,  32'b0011_0_0_1_1,      8,  15,  -16,   0};
      vecs[8] = '{4'd2,  32'b0001_10_1_1,       8, -17,   -1,   0};

      @(negedge clk);
      @(negedge clk);
      check_output("rst_axiov", bus.axiov, 0);
      check_output("rst_axiir", bus.axiir, 0);
      check_output("rst_done", done, 0);
      check_output("rst_lk_len", bus.lk_len, 0);
      check_output("rst_lk_code", int'(bus.lk_code), 0);
      check_output("rst_x", bus.x_val, 0);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 9; i++) apply_stimulus(vecs[i], i);

      // Two pairs in one run; done only after the second accept.
      start_run(4'd0, 9'd2);
      put_bit(1'b1);
      wait_out(lat);
      check_output("seq1_p0_x", bus.x_val, 0);
      check_output("seq1_p0_y", bus.y_val, 0);
      accept_pair();
      check_output("seq1_no_early_done", done, 0);
      for (int i = 3; i >= 0; i--) put_bit(4'b0101 >> i);
      wait_out(lat);
      check_output("seq1_p1_x", bus.x_val, -1);
      check_output("seq1_p1_y", bus.y_val, 0);
      accept_pair();
      check_output("seq1_done", done, 1);
      @(negedge clk);
      check_output("seq1_done_low", done, 0);

      // Downstream backpressure for five cycles while the source offers a bit.
      start_run(4'd0, 9'd1);
      for (int i = 3; i >= 0; i--) put_bit(4'b0101 >> i);
      wait_out(lat);
      sx = bus.x_val;
      sy = bus.y_val;
      c0 = consumed;
      bus.axiiv = 1'b1;
      bus.axiid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         check_output($sformatf("bp%0d_axiov", k), bus.axiov, 1);
         check_output($sformatf("bp%0d_axiir", k), bus.axiir, 0);
         check_output($sformatf("bp%0d_x", k), bus.x_val, -1);
         check_output($sformatf("bp%0d_y", k), bus.y_val, sy);
         @(negedge clk);
      end
      bus.axiiv = 1'b0;
      check_output("bp_no_bits", consumed - c0, 0);
      check_output("bp_stable_x", bus.x_val, sx);
      accept_pair();
      check_output("bp_done", done, 1);
      @(negedge clk);

      // Zero-pair run.
      start_run(4'd0, 9'd0);
      check_output("zero_done", done, 1);
      check_output("zero_axiov", bus.axiov, 0);
      @(negedge clk);
      check_output("zero_done_low", done, 0);
      check_output("zero_axiov_later", bus.axiov, 0);

      // Reset while shifting x linbits.
      start_run(4'd4, 9'd1);
      for (int i = 3; i >= 0; i--) put_bit(4'b0011 >> i);
      put_bit(1'b0);
      check_output("linx_axiir", bus.axiir, 1);
      #2 rst = 1'b0;
      #1;
      check_output("midrst_axiir", bus.axiir, 0);
      check_output("midrst_axiov", bus.axiov, 0);
      check_output("midrst_done", done, 0);
      @(negedge clk);
      rst = 1'b1;
      c0 = consumed;
      bus.axiiv = 1'b1;
      bus.axiid = 1'b1;
      repeat (3) @(negedge clk);
      bus.axiiv = 1'b0;
      check_output("idle_no_bits", consumed - c0, 0);
      check_output("idle_axiov", bus.axiov, 0);
      check_output("idle_lk_len", bus.lk_len, 0);

`ifdef HUFF_ERR_EN
      // Codeword overflow aborts the run with an error, not done.
      start_run(4'd0, 9'd1);
      for (int i = 0; i < 4; i++) put_bit(1'b0);
      check_output("ovf_axiir", bus.axiir, 0);
      @(negedge clk);
      check_output("ovf_err", err, 1);
      check_output("ovf_err_flag", err_flag, 1);
      check_output("ovf_no_done", done, 0);
      @(negedge clk);
      check_output("ovf_err_low", err, 0);
      check_output("ovf_flag_held", err_flag, 1);
      check_output("ovf_idle_axiir", bus.axiir, 0);
      start_run(4'd0, 9'd0);
      check_output("ovf_flag_clear", err_flag, 0);
      check_output("ovf_restart_done", done, 1);
`else
      // Codeword overflow saturates and keeps discarding bits.
      start_run(4'd0, 9'd1);
      for (int i = 0; i < MB + 2; i++) put_bit(1'b0);
      check_output("sat_lk_len", bus.lk_len, MB);
      check_output("sat_axiir", bus.axiir, 1);
      check_output("sat_axiov", bus.axiov, 0);
      check_output("sat_lk_code", int'(bus.lk_code), 0);
      do_reset();
      check_output("sat_reset_lk_len", bus.lk_len, 0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
